// File: rtl/dec_pipeline.sv
`default_nettype none
// =====================================================================
// dec_pipeline : fully unrolled 11-stage AES-128 inverse cipher, rev 1.0
// =====================================================================
module dec_pipeline (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] rkey,
  input  logic [3:0]   addr,
  input  logic [127:0] din,
  input  logic         din_vld,
  output logic [127:0] dout,
  output logic         dout_vld
);

  localparam int NSTG = 11;

  logic [127:0] key [1:NSTG];
  logic [127:0] st  [0:NSTG-1];
  logic [127:0] nxt [0:NSTG-1];
  logic [NSTG-1:0] vld;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    int dst;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = 4 * ((c + 4 - r) % 4) + r;
        dst = 4 * c + r;
        o[127-8*dst -: 8] = inv_sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Stage r consumes round key 10-r, i.e. K[11-r]
  always_comb begin
    nxt[0] = din ^ key[11];
    for (int r = 1; r <= 9; r++) begin
      nxt[r] = inv_mix(inv_sub_shift(st[r-1]) ^ key[11-r]);
    end
    nxt[10] = inv_sub_shift(st[9]) ^ key[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= NSTG; i++) key[i] <= '0;
    end else begin
      for (int i = 1; i <= NSTG; i++) begin
        if (addr == 4'(i)) key[i] <= rkey;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTG; i++) st[i] <= '0;
      vld <= '0;
    end else begin
      for (int i = 0; i < NSTG; i++) st[i] <= nxt[i];
      vld <= {vld[NSTG-2:0], din_vld};
    end
  end

  assign dout     = st[NSTG-1];
  assign dout_vld = vld[NSTG-1];

endmodule
`default_nettype wire

// File: tb/tb_dec_pipeline.sv
`default_nettype none
// =====================================================================
// tb_dec_pipeline : directed bench for the AES-128 decryption pipeline
// =====================================================================
module tb_dec_pipeline;

  logic         clk;
  logic         rst;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic [127:0] din;
  logic         din_vld;
  logic [127:0] dout;
  logic         dout_vld;

  int passed;
  int total;

  logic [7:0]   sbox [0:255];
  logic [127:0] rk   [0:10];
  logic [10:0]  mv;
  logic [127:0] mp   [0:10];

  dec_pipeline dut (
    .clk      (clk),
    .rst      (rst),
    .rkey     (rkey),
    .addr     (addr),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from brute-force inverse plus the forward affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      x = inv;
      sbox[a] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    int dst;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = 4 * ((c + r) % 4) + r;
        dst = 4 * c + r;
        o[127-8*dst -: 8] = sbox[s[127-8*src -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
      o[103-32*c -: 8] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= 9; r++) s = mix(sub_shift(s)) ^ rk[r];
    return sub_shift(s) ^ rk[10];
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, model the 11-deep latency, check at next negedge
  task automatic tick(input logic v, input logic [127:0] c, input logic [127:0] p);
    din     = c;
    din_vld = v;
    @(posedge clk);
    mv = {mv[9:0], v};
    for (int i = 10; i > 0; i--) mp[i] = mp[i-1];
    mp[0] = p;
    @(negedge clk);
    check("dout_vld", {127'd0, dout_vld}, {127'd0, mv[10]});
    if (mv[10]) check("dout", dout, mp[10]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
  endtask

  task automatic load_keys();
    for (int n = 1; n <= 11; n++) begin
      addr = 4'(n);
      rkey = rk[n-1];
      tick(1'b0, '0, '0);
    end
    addr = 4'd0;
    rkey = '0;
  endtask

  task automatic clear_model();
    mv = '0;
    for (int i = 0; i < 11; i++) mp[i] = '0;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] p;
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    rkey    = '0;
    addr    = 4'd0;
    din     = '0;
    din_vld = 1'b0;
    clear_model();
    build_sbox();

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dout", dout, '0);
    check("reset_vld", {127'd0, dout_vld}, '0);
    rst = 1'b1;

    // FIPS-197 C.1 single block
    expand(C1_KEY);
    load_keys();
    tick(1'b1, C1_CT, C1_PT);
    idle(13);

    // Writes outside 1..11 must leave the key file untouched
    addr = 4'd0;
    rkey = {128{1'b1}};
    tick(1'b0, '0, '0);
    for (int a = 12; a <= 15; a++) begin
      addr = 4'(a);
      tick(1'b0, '0, '0);
    end
    addr = 4'd0;
    rkey = '0;
    tick(1'b1, C1_CT, C1_PT);
    idle(12);

    // FIPS-197 App.B
    expand(B_KEY);
    load_keys();
    tick(1'b1, B_CT, B_PT);
    idle(12);

    // Streaming with a bubble, ciphertexts from the forward model
    for (int i = 0; i < 20; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      tick(1'b1, encrypt(p), p);
    end
    idle(3);
    for (int i = 0; i < 5; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      tick(1'b1, encrypt(p), p);
    end
    idle(12);

    // Reset mid-stream, checked between clock edges
    expand(C1_KEY);
    load_keys();
    for (int i = 0; i < 5; i++) tick(1'b1, C1_CT, C1_PT);
    din_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout", dout, '0);
    check("async_rst_vld", {127'd0, dout_vld}, '0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_keys();
    tick(1'b1, C1_CT, C1_PT);
    idle(12);

    // Random key, long random stream with random gaps
    expand({$urandom, $urandom, $urandom, $urandom});
    load_keys();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        tick(1'b1, encrypt(p), p);
      end else begin
        tick(1'b0, '0, '0);
      end
    end
    idle(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
